// File: rtl/md_unit.sv
// rtl/md_unit.sv - execute-stage multiply/divide unit with HI/LO registers
// Multi-cycle latency is modelled by a busy counter; the result is committed on its last cycle.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MD_start,
  input  logic [1:0]  MDop,
  input  logic        MD_mtHI,
  input  logic        MD_mtLO,
  input  logic        MD_Rsel,
  input  logic        usehl_D,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]    op_q, op_d;

  logic        is_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] abs_a, abs_b, quo_u, rem_u, quo, rem;

  // Signed division works on magnitudes so 0x80000000 / -1 cannot overflow.
  always_comb begin
    is_signed = ~op_q[0];
    mul_a = is_signed ? {{32{op_a_q[31]}}, op_a_q} : {32'b0, op_a_q};
    mul_b = is_signed ? {{32{op_b_q[31]}}, op_b_q} : {32'b0, op_b_q};
    prod  = mul_a * mul_b;
    abs_a = (is_signed && op_a_q[31]) ? -op_a_q : op_a_q;
    abs_b = (is_signed && op_b_q[31]) ? -op_b_q : op_b_q;
    quo_u = 32'b0;
    rem_u = 32'b0;
    if (abs_b != 32'b0) begin
      quo_u = abs_a / abs_b;
      rem_u = abs_a % abs_b;
    end
    quo = (is_signed && (op_a_q[31] ^ op_b_q[31])) ? -quo_u : quo_u;
    rem = (is_signed && op_a_q[31]) ? -rem_u : rem_u;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (MD_start) begin
          op_a_d  = A;
          op_b_d  = B;
          op_d    = MDop;
          cnt_d   = MDop[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = RUN;
        end else begin
          if (MD_mtHI) hi_d = A;
          if (MD_mtLO) lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!op_q[1]) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (op_b_q != 32'b0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'b0;
      lo_q    <= 32'b0;
      op_a_q  <= 32'b0;
      op_b_q  <= 32'b0;
      op_q    <= 2'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      op_q    <= op_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign md_stall = usehl_D & (MD_start | busy);
  assign rd_data  = MD_Rsel ? lo_q : hi_q;
  assign HI_out   = hi_q;
  assign LO_out   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
// Reference results come from 64-bit integer arithmetic on the operands.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MD_start, MD_mtHI, MD_mtLO, MD_Rsel, usehl_D;
  logic [1:0]  MDop;
  logic [31:0] A, B;
  logic [31:0] rd_data, HI_out, LO_out;
  logic        busy, md_stall;

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] exp_hi, exp_lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MD_start(MD_start), .MDop(MDop),
    .MD_mtHI(MD_mtHI), .MD_mtLO(MD_mtLO), .MD_Rsel(MD_Rsel), .usehl_D(usehl_D),
    .A(A), .B(B), .rd_data(rd_data), .busy(busy), .md_stall(md_stall),
    .HI_out(HI_out), .LO_out(LO_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      2'b10: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
      default: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
    endcase
  endtask

  task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic usehl, input logic noise, input logic mt_at_start);
    int n;
    n = op[1] ? 10 : 5;
    MD_start = 1'b1; MDop = op; A = a; B = b; usehl_D = usehl;
    MD_mtHI = mt_at_start; MD_mtLO = mt_at_start;
    #1 check("stall_start", 32'(md_stall), 32'(usehl));
    ref_op(op, a, b);
    step();
    MD_start = 1'b0; MD_mtHI = 1'b0; MD_mtLO = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        A = $urandom; B = $urandom; MDop = 2'($urandom);
        MD_start = (i == 2); MD_mtHI = (i == 2); MD_mtLO = (i == 2);
      end
      #1;
      check("busy_run", 32'(busy), 32'd1);
      check("stall_run", 32'(md_stall), 32'(usehl));
      step();
    end
    MD_start = 1'b0; MD_mtHI = 1'b0; MD_mtLO = 1'b0;
    check("busy_done", 32'(busy), 32'd0);
    check("hi_result", HI_out, exp_hi);
    check("lo_result", LO_out, exp_lo);
    MD_Rsel = 1'b1;
    #1 check("rd_lo", rd_data, exp_lo);
    MD_Rsel = 1'b0;
    #1 check("rd_hi", rd_data, exp_hi);
  endtask

  task automatic mt(input logic to_hi, input logic [31:0] v);
    MD_mtHI = to_hi; MD_mtLO = ~to_hi; A = v;
    step();
    MD_mtHI = 1'b0; MD_mtLO = 1'b0;
    if (to_hi) exp_hi = v; else exp_lo = v;
    check("mt_hi", HI_out, exp_hi);
    check("mt_lo", LO_out, exp_lo);
    check("mt_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; MD_start = 1'b0; MDop = 2'b0; MD_mtHI = 1'b0; MD_mtLO = 1'b0;
    MD_Rsel = 1'b0; usehl_D = 1'b0; A = 32'b0; B = 32'b0;
    exp_hi = 32'b0; exp_lo = 32'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI_out, 32'h0);
    check("rst_lo", LO_out, 32'h0);
    reset = 1'b0;
    step();

    run_md(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1'b0);
    check("mult_hi_const", HI_out, 32'hFFFFFFFF);
    check("mult_lo_const", LO_out, 32'hFFFFFFFE);
    run_md(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1'b0);
    check("multu_hi_const", HI_out, 32'h00000001);
    check("multu_lo_const", LO_out, 32'hFFFFFFFE);
    run_md(2'b10, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    check("div_hi_const", HI_out, 32'hFFFFFFFF);
    check("div_lo_const", LO_out, 32'hFFFFFFFD);
    run_md(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    check("divu_hi_const", HI_out, 32'h00000001);
    check("divu_lo_const", LO_out, 32'h7FFFFFFC);

    mt(1'b1, 32'h1234);
    mt(1'b0, 32'h5678);
    run_md(2'b10, 32'h11111111, 32'd0, 1'b0, 1'b0, 1'b0);
    check("div0_hi", HI_out, 32'h1234);
    check("div0_lo", LO_out, 32'h5678);
    run_md(2'b11, 32'h11111111, 32'd0, 1'b0, 1'b0, 1'b0);
    run_md(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    check("ovf_hi", HI_out, 32'h0);
    check("ovf_lo", LO_out, 32'h80000000);

    // start wins over a coinciding mthi/mtlo; restart and mt during RUN are ignored
    run_md(2'b00, 32'd12345, 32'hFFFF0003, 1'b1, 1'b1, 1'b1);
    run_md(2'b10, 32'hDEADBEEF, 32'd77, 1'b1, 1'b1, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 4) == 0) mt(1'($urandom), $urandom);
      run_md(op, a, b, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    MD_start = 1'b1; MDop = 2'b10; A = 32'd100; B = 32'd3;
    step();
    MD_start = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI_out, 32'h0);
    check("abort_lo", LO_out, 32'h0);
    exp_hi = 32'h0; exp_lo = 32'h0;
    step();
    reset = 1'b0;
    step();
    check("post_abort_busy", 32'(busy), 32'd0);
    mt(1'b0, 32'd7);
    MD_Rsel = 1'b1;
    #1 check("rd_after_mtlo", rd_data, 32'd7);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
